// File: rtl/hfrv_mem_responder.sv
// HF-RISC bus memory responder: word array with byte writes, programmable wait states, OOR counter.
// Optional wait-state jitter from a 16-bit LFSR when HFRV_MEM_RESP_JITTER_EN is defined.
module hfrv_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [3:0]  data_we,
   input  logic [31:0] data_write,
   output logic [31:0] data_read,
   output logic        stall,
   output logic [15:0] oor_count
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state;
   logic [4:0]    cnt;
   logic [4:0]    wait_w;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_we;
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          complete;
   logic [31:0]   mem [DEPTH_WORDS];

`ifdef HFRV_MEM_RESP_JITTER_EN
   logic [15:0] lfsr;
   always_comb wait_w = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
   always_comb wait_w = 5'(WAIT_STATES);
`endif

   // In IDLE the live bus is the access; in WAIT the latched copy is used.
   always_comb begin
      acc_addr  = (state == IDLE) ? address    : lat_addr;
      acc_we    = (state == IDLE) ? data_we    : lat_we;
      acc_wdata = (state == IDLE) ? data_write : lat_wdata;
      complete  = (state == IDLE) ? (wait_w == 5'd0) : (cnt == 5'd1);
      off       = acc_addr - BASE_ADDR;
      idx       = AW'(off >> 2);
      // Addresses below BASE_ADDR wrap to large offsets and fail this test too.
      in_range  = ((off >> (AW + 2)) == 32'd0);
   end

   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         lat_addr  <= address;
         lat_we    <= data_we;
         lat_wdata <= data_write;
      end
   end

   // Gating with reset keeps an aborted or in-reset access from committing.
   always_ff @(posedge clk) begin
      if (reset && complete && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_we[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         stall     <= 1'b0;
         data_read <= 32'h0000_0000;
         oor_count <= 16'h0000;
`ifdef HFRV_MEM_RESP_JITTER_EN
         lfsr      <= 16'hACE1;
`endif
      end else begin
         if (complete) begin
            data_read <= in_range ? mem[idx] : 32'h0000_0000;
            if (!in_range && oor_count != 16'hFFFF) oor_count <= oor_count + 16'd1;
         end
         case (state)
            IDLE: begin
`ifdef HFRV_MEM_RESP_JITTER_EN
               lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
               if (wait_w != 5'd0) begin
                  state <= WAIT;
                  cnt   <= wait_w;
                  stall <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 5'd1) begin
                  state <= IDLE;
                  cnt   <= 5'd0;
                  stall <= 1'b0;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hfrv_mem_responder.sv
// Bench for hfrv_mem_responder: zero-wait instance (table + random model) and three-wait instance (timing sequences).
module tb_hfrv_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] a0 = '0, wd0 = '0, a3 = '0, wd3 = '0;
   logic [3:0]  we0 = '0, we3 = '0;
   logic [31:0] rd0, rd3;
   logic        s0, s3;
   logic [15:0] o0, o3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hfrv_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .address(a0), .data_we(we0), .data_write(wd0),
      .data_read(rd0), .stall(s0), .oor_count(o0));

   hfrv_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(reset), .address(a3), .data_we(we3), .data_write(wd3),
      .data_read(rd3), .stall(s3), .oor_count(o3));

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wd;
      logic        chk;
      logic [31:0] rd;
      logic [15:0] oor;
   } vec_t;

   vec_t        tbl [10];
   logic [31:0] mdl [16];
   int          oor_m;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_idle3();
      int guard = 0;
      while (s3 && guard < 20) begin
         step();
         guard++;
      end
      if (s3) chk("dut3_idle_timeout", {31'b0, s3}, 32'd0);
   endtask

   task automatic acc3(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input bit chkd, input logic [31:0] expd, input string nm);
      wait_idle3();
      a3 = a; we3 = we; wd3 = wd;
      step();
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("%s_stall_k+%0d", nm, i), {31'b0, s3}, 32'd1);
         step();
      end
      chk($sformatf("%s_stall_k+4", nm), {31'b0, s3}, 32'd0);
      if (chkd) chk($sformatf("%s_data", nm), rd3, expd);
      a3 = '0; we3 = '0; wd3 = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0};
      tbl[1] = '{32'h10,   4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 16'd0};
      tbl[2] = '{32'h10,   4'h1, 32'h000000AA, 1'b1, 32'hDEADBEEF, 16'd0};
      tbl[3] = '{32'h10,   4'h0, 32'h0,        1'b1, 32'hDEADBEAA, 16'd0};
      tbl[4] = '{32'h4000, 4'hF, 32'h12345678, 1'b1, 32'h0,        16'd1};
      tbl[5] = '{32'h4000, 4'h0, 32'h0,        1'b1, 32'h0,        16'd2};
      tbl[6] = '{32'h10,   4'h6, 32'h11223344, 1'b1, 32'hDEADBEAA, 16'd2};
      tbl[7] = '{32'h12,   4'h0, 32'h0,        1'b1, 32'hDE2233AA, 16'd2};
      tbl[8] = '{32'h3FFC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        16'd2};
      tbl[9] = '{32'h3FFC, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 16'd2};

      // Reset values
      repeat (3) step();
      chk("rst_rd0", rd0, 32'h0);
      chk("rst_stall0", {31'b0, s0}, 32'd0);
      chk("rst_oor0", {16'b0, o0}, 32'd0);
      chk("rst_rd3", rd3, 32'h0);
      chk("rst_stall3", {31'b0, s3}, 32'd0);
      chk("rst_oor3", {16'b0, o3}, 32'd0);
      reset = 1'b1;

      // Table-driven zero-wait sequence
      for (int i = 0; i < 10; i++) begin
         a0 = tbl[i].addr; we0 = tbl[i].we; wd0 = tbl[i].wd;
         step();
         if (tbl[i].chk) chk($sformatf("tbl%0d_rd", i), rd0, tbl[i].rd);
         chk($sformatf("tbl%0d_oor", i), {16'b0, o0}, {16'b0, tbl[i].oor});
         chk($sformatf("tbl%0d_stall", i), {31'b0, s0}, 32'd0);
      end

      // Random back-to-back traffic against a word-array model
      oor_m = 2;
      for (int w = 0; w < 16; w++) begin
         a0 = 32'(w) << 2; we0 = 4'hF; wd0 = $urandom;
         mdl[w] = wd0;
         step();
         chk($sformatf("init%0d_stall", w), {31'b0, s0}, 32'd0);
      end
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ad, exp;
         logic [3:0]  we;
         logic [31:0] wd;
         int          w;
         w  = int'($urandom_range(0, 15));
         we = 4'($urandom_range(0, 15));
         wd = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: ad = 32'h4000 + ($urandom_range(0, 1023) << 2);
               1: ad = 32'hFFFF_FFFC;
               default: ad = 32'h8000_0000 | $urandom_range(0, 255);
            endcase
            exp = 32'h0;
            if (oor_m < 16'hFFFF) oor_m++;
         end else begin
            ad = (32'(w) << 2) | 32'($urandom_range(0, 3));
            exp = mdl[w];
            for (int b = 0; b < 4; b++) if (we[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
         end
         a0 = ad; we0 = we; wd0 = wd;
         step();
         chk($sformatf("rnd%0d_rd", n), rd0, exp);
         chk($sformatf("rnd%0d_oor", n), {16'b0, o0}, 32'(oor_m));
         chk($sformatf("rnd%0d_stall", n), {31'b0, s0}, 32'd0);
      end
      a0 = '0; we0 = '0; wd0 = '0;

      // Three wait states: write, read back, out-of-range
      acc3(32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "w3_wr10");
      acc3(32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, "w3_rd10");
      acc3(32'h10, 4'h1, 32'h000000AA, 1'b1, 32'hDEADBEEF, "w3_bw10");
      acc3(32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEAA, "w3_rd10b");
      acc3(32'h20, 4'hF, 32'h00000077, 1'b0, 32'h0, "w3_wr20");
      acc3(32'h4000, 4'hF, 32'h12345678, 1'b1, 32'h0, "w3_oor");
      chk("w3_oor_count", {16'b0, o3}, 32'd1);
      acc3(32'h4000, 4'h0, 32'h0, 1'b1, 32'h0, "w3_oor_rd");
      chk("w3_oor_count2", {16'b0, o3}, 32'd2);

      // Reset asserted in cycle k+2 of a pending write
      wait_idle3();
      a3 = 32'h20; we3 = 4'hF; wd3 = 32'h55;
      step();
      chk("mid_stall_k+1", {31'b0, s3}, 32'd1);
      step();
      reset = 1'b0;
      #1;
      chk("mid_rst_stall", {31'b0, s3}, 32'd0);
      chk("mid_rst_rd", rd3, 32'h0);
      chk("mid_rst_oor", {16'b0, o3}, 32'd0);
      a3 = '0; we3 = '0; wd3 = '0;
      step();
      reset = 1'b1;
      step();
      chk("rel_first_edge_accepts", {31'b0, s3}, 32'd1);
      acc3(32'h20, 4'h0, 32'h0, 1'b1, 32'h00000077, "w3_rd20_after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hfrv_mem_responder.md
# hfrv_mem_responder

Synthesizable memory responder: the memory end of the HF-RISC CPU data/instruction bus (`address`, `data_write`, `data_we` in; `data_read`, `stall` out). It answers each CPU access from an internal word array and inserts a programmable number of wait states by holding `stall` high. It also counts out-of-range accesses. It sits between the CPU bus and the testbench as the standard memory model and is reusable on FPGA builds.

## Interface
- `DEPTH_WORDS`, 4096: array size in 32-bit words (power of two, ≥ 2).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0 (aligned to DEPTH_WORDS*4).
- `WAIT_STATES`, 0: fixed stall cycles per access (0–15).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `address` in 32: byte address; bits [1:0] are ignored.
- `data_we` in 4: byte write enables; `data_we[i]` writes bits [8i+7:8i]; 4'b0000 = read.
- `data_write` in 32: write data.
- `data_read` out 32: registered read data.
- `stall` out 1: registered; high holds the CPU, which keeps its bus inputs stable.
- `oor_count` out 16: saturating count of out-of-range accesses.

## Operation
- FSM states: IDLE and WAIT.
- IDLE: at every rising edge, the responder accepts the bus as a new access and latches `address`, `data_we` and `data_write`.
  - Wait count W = WAIT_STATES (plus jitter, see Configuration).
  - If W = 0, the access completes at the same edge and the FSM stays in IDLE.
  - If W > 0, the FSM goes to WAIT with `cnt` = W and `stall` goes to 1.
- WAIT: bus inputs are ignored and `cnt` decrements each edge.
  - At the edge where `cnt` = 1, the access completes, `stall` goes to 0, and the FSM returns to IDLE.
- Completion, in one edge:
  - `data_read` ← array[idx] (old contents; read-before-write).
  - Array bytes with `data_we[i]` = 1 are written from the latched `data_write`.
- Index: idx = (address − BASE_ADDR) >> 2, taking log2(DEPTH_WORDS) bits.
- In range means BASE_ADDR ≤ address < BASE_ADDR + 4·DEPTH_WORDS.
- Out-of-range access, at completion:
  - `data_read` ← 32'h0000_0000.
  - The write is dropped.
  - `oor_count` increments and saturates at 16'hFFFF.
- Array contents are not reset.

## Timing
- Reset values: `data_read` = 0, `stall` = 0, `oor_count` = 0, state IDLE, `cnt` = 0, LFSR = 16'hACE1.
- Access presented in cycle k:
  - `stall` is high during cycles k+1 .. k+W.
  - `data_read` is valid in cycle k+W+1, the first cycle with `stall` low.
  - The write is visible to an access presented in cycle k+W+1 or later.
- With W = 0, the block sustains back-to-back accesses at one per cycle, and `stall` never rises.
- A read in cycle k+1 of a word written in cycle k (W = 0) returns the new data.
- Reset asserted mid-WAIT:
  - The pending access is aborted.
  - Its write is never committed.
  - Outputs take reset values immediately.
- Reset release: the first edge with `reset` = 1 samples the bus as a new access.
- A write with `data_we` = 4'b1111 and a partial write behave identically except for the bytes written.

## Configuration
- Macro: `HFRV_MEM_RESP_JITTER_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per accepted access.
  - W = WAIT_STATES + lfsr[1:0], sampled before the advance, so W ranges from WAIT_STATES to WAIT_STATES+3.
- Undefined: there is no LFSR, and W = WAIT_STATES exactly.
- Either way, the data returned is identical; only `stall` timing differs.

## Test plan
- Reset values: hold `reset` = 0 for 3 cycles → `data_read` = 0, `stall` = 0, `oor_count` = 0.
- Write/read, W = 0: write 32'hDEADBEEF at 0x10 with `data_we` = 4'hF, then read 0x10 → `data_read` = 32'hDEADBEEF one cycle later, with no stall.
- Byte write: write 32'h000000AA at 0x10 with `data_we` = 4'b0001, then read → 32'hDEADBEAA.
- Wait states, WAIT_STATES = 3: read 0x10 in cycle k → `stall` is high in k+1..k+3, and data is valid in k+4.
- Out of range, DEPTH_WORDS = 4096: write 32'h12345678 to 0x0000_4000 → write dropped, `oor_count` = 1; a read there returns 0.
- Reset mid-stall, WAIT_STATES = 3: write 32'h55 to 0x20, and assert `reset` in cycle k+2 → `stall` = 0 immediately; a later read of 0x20 returns the old contents.
